// File: rtl/ca_rule_scheduler.sv
// Rule-table sequencer for the cellular-automaton VGA datapath: scroll position, rule/colour
// selection and reseed requests. Define CA_RULE_WRITE_EN to make the rule table writable.
module ca_rule_scheduler #(
    parameter int unsigned NUM_RULES = 8,
    parameter int unsigned BAND_ROWS = 256,
    localparam int unsigned IDX_W = $clog2(NUM_RULES),
    localparam int unsigned BAND_W = $clog2(BAND_ROWS),
    localparam int unsigned POS_W = IDX_W + BAND_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start_i,
    input  logic             row_tick_i,
    input  logic [1:0]       mode_i,
    input  logic             btn_next_i,
    input  logic             btn_reseed_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_addr_i,
    input  logic [7:0]       wr_data_i,
    output logic [7:0]       rule_o,
    output logic [IDX_W-1:0] rule_idx_o,
    output logic [5:0]       rule_color_o,
    output logic             reseed_o
);

    localparam logic [1:0] ModeAuto   = 2'b00;
    localparam logic [1:0] ModeSingle = 2'b10;
    localparam logic [5:0] ColorGrey  = 6'b010101;

    function automatic logic [7:0] rom_val(input int unsigned i);
        case (i % 8)
            0:       return 8'd30;
            1:       return 8'd110;
            2:       return 8'd22;
            3:       return 8'd73;
            4:       return 8'd90;
            5:       return 8'd146;
            6:       return 8'd105;
            default: return 8'd102;
        endcase
    endfunction

    // Synchronizers and edge-detect history
    logic [1:0] mode_s1_q, mode_s2_q;
    logic       next_s1_q, next_s2_q, next_prev_q;
    logic       rsd_s1_q, rsd_s2_q, rsd_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1_q   <= 2'b00;
            mode_s2_q   <= 2'b00;
            next_s1_q   <= 1'b0;
            next_s2_q   <= 1'b0;
            next_prev_q <= 1'b0;
            rsd_s1_q    <= 1'b0;
            rsd_s2_q    <= 1'b0;
            rsd_prev_q  <= 1'b0;
        end else begin
            mode_s1_q   <= mode_i;
            mode_s2_q   <= mode_s1_q;
            next_s1_q   <= btn_next_i;
            next_s2_q   <= next_s1_q;
            next_prev_q <= next_s2_q;
            rsd_s1_q    <= btn_reseed_i;
            rsd_s2_q    <= rsd_s1_q;
            rsd_prev_q  <= rsd_s2_q;
        end
    end

    // Scheduler state
    logic [1:0]       mode_q, mode_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [POS_W-1:0] base_q, base_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic             pend_q, pend_d;

    // Registered outputs
    logic [7:0]       rule_q, rule_d;
    logic [IDX_W-1:0] idx_q, idx;
    logic [5:0]       color_q, color_d;
    logic             reseed_q, reseed_d;

    logic             is_single, is_auto, next_edge, reseed_edge;
    logic [IDX_W-1:0] band_inc;
    logic [POS_W-1:0] jump_base;
    logic [7:0]       table_rd;

    assign is_single   = (mode_q == ModeSingle);
    assign is_auto     = (mode_q == ModeAuto);
    assign next_edge   = next_s2_q & ~next_prev_q;
    assign reseed_edge = rsd_s2_q & ~rsd_prev_q;
    assign band_inc    = base_q[POS_W-1:BAND_W] + IDX_W'(1);
    assign jump_base   = {band_inc, {BAND_W{1'b0}}};
    assign idx         = is_single ? sel_q : pos_q[POS_W-1:BAND_W];

`ifdef CA_RULE_WRITE_EN
    logic [7:0] table_q [NUM_RULES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_RULES; i++) begin
                table_q[i] <= rom_val(i);
            end
        end else if (wr_en_i) begin
            table_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign table_rd = table_q[idx];
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
    assign table_rd  = rom_val(32'(idx));
`endif

    always_comb begin
        mode_d   = mode_q;
        pos_d    = pos_q;
        base_d   = base_q;
        sel_d    = sel_q;
        pend_d   = pend_q;
        reseed_d = 1'b0;

        // A band jump overrides the per-frame auto-scroll increment
        if (next_edge && !is_single) begin
            base_d = jump_base;
        end else if (frame_start_i && is_auto) begin
            base_d = base_q + POS_W'(1);
        end

        if (frame_start_i) begin
            pos_d  = base_d;
            mode_d = mode_s2_q;
        end else if (row_tick_i) begin
            pos_d = pos_q + POS_W'(1);
        end

        if (next_edge && is_single) begin
            sel_d = sel_q + IDX_W'(1);
        end

        // A press landing on the issuing frame_start stays pending for the next frame
        if (frame_start_i && pend_q) begin
            reseed_d = 1'b1;
        end
        pend_d = reseed_edge | (pend_q & ~frame_start_i);

        rule_d  = table_rd;
        color_d = (table_rd[6:1] != 6'd0) ? table_rd[6:1] : ColorGrey;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= ModeAuto;
            pos_q    <= '0;
            base_q   <= '0;
            sel_q    <= '0;
            pend_q   <= 1'b1;
            rule_q   <= 8'd30;
            idx_q    <= '0;
            color_q  <= 6'b001111;
            reseed_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            pos_q    <= pos_d;
            base_q   <= base_d;
            sel_q    <= sel_d;
            pend_q   <= pend_d;
            rule_q   <= rule_d;
            idx_q    <= idx;
            color_q  <= color_d;
            reseed_q <= reseed_d;
        end
    end

    assign rule_o       = rule_q;
    assign rule_idx_o   = idx_q;
    assign rule_color_o = color_q;
    assign reseed_o     = reseed_q;

endmodule
